alu_op_issue: RTL and testbench

Issue stage feeding the 32-bit ALU. It accepts decoded instruction fields plus register-file operands under a valid/ready handshake. It translates opcode/funct into the ALU's 4-bit control encoding and selects operands A and B. It then buffers the result in a small FIFO whose head drives ALUControl/A/B directly, so the execute stage consumes one operation per accepted handshake.

---
 rtl/alu_ctrl_pkg.sv | 69 ++++++
 rtl/alu_op_decode.sv | 122 ++++++++++++
 rtl/alu_op_issue.sv | 106 ++++++++++
 tb/tb_alu_op_issue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU issue stage: ALU control codes, the opcode and
// funct values the decoder understands, and the layout of one FIFO entry.
package alu_ctrl_pkg;

   // ALU control codes
   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_ADD  = 4'd2;
   localparam logic [3:0] ALU_NOR  = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SUB  = 4'd6;
   localparam logic [3:0] ALU_SLT  = 4'd7;
   localparam logic [3:0] ALU_JUMP = 4'd8;
   localparam logic [3:0] ALU_MUL  = 4'd9;
   localparam logic [3:0] ALU_SLL  = 4'd10;
   localparam logic [3:0] ALU_SGT  = 4'd11;
   localparam logic [3:0] ALU_CLZO = 4'd12;
   localparam logic [3:0] ALU_ROTR = 4'd13;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE    = 6'h00;
   localparam logic [5:0] OP_J        = 6'h02;
   localparam logic [5:0] OP_JAL      = 6'h03;
   localparam logic [5:0] OP_BEQ      = 6'h04;
   localparam logic [5:0] OP_BNE      = 6'h05;
   localparam logic [5:0] OP_ADDI     = 6'h08;
   localparam logic [5:0] OP_ADDIU    = 6'h09;
   localparam logic [5:0] OP_SLTI     = 6'h0A;
   localparam logic [5:0] OP_ANDI     = 6'h0C;
   localparam logic [5:0] OP_ORI      = 6'h0D;
   localparam logic [5:0] OP_XORI     = 6'h0E;
   localparam logic [5:0] OP_LUI      = 6'h0F;
   localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
   localparam logic [5:0] OP_LW       = 6'h23;
   localparam logic [5:0] OP_SW       = 6'h2B;

   // R-type funct values
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_ROTR = 6'h02;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   // SPECIAL2 funct values
   localparam logic [5:0] FN_MUL = 6'h02;
   localparam logic [5:0] FN_CLZ = 6'h20;
   localparam logic [5:0] FN_CLO = 6'h21;

   // rs field value that turns funct 0x02 into a rotate
   localparam logic [4:0] RS_ROTR = 5'd1;

   // One buffered operation: control + A + B + illegal flag
   localparam int ENTRY_W = 4 + 32 + 32 + 1;

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic        illegal;
   } entry_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of instruction fields into ALU control and operands.
// Unsupported encodings come out as Illegal=1 with control and operands zeroed.
module alu_op_decode
   import alu_ctrl_pkg::*;
(
   input  logic [5:0]  Opcode,
   input  logic [5:0]  Funct,
   input  logic [4:0]  RsField,
   input  logic [4:0]  Shamt,
   input  logic [15:0] Imm16,
   input  logic [31:0] RsData,
   input  logic [31:0] RtData,
   output logic [3:0]  ALUControl,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic        Illegal
);

   logic [31:0] se, ze, sh;
   logic [3:0]  ctrl;
   logic [31:0] a, b;
   logic        bad;

   assign se = {{16{Imm16[15]}}, Imm16};
   assign ze = {16'h0000, Imm16};
   assign sh = {27'd0, Shamt};

   // Opcode/funct to control and operand selection; bad encodings flagged
   always_comb begin
      ctrl = ALU_AND;
      a    = RsData;
      b    = 32'd0;
      bad  = 1'b0;
      case (Opcode)
         OP_RTYPE: begin
            b = RtData;
            case (Funct)
               FN_AND:          ctrl = ALU_AND;
               FN_OR:           ctrl = ALU_OR;
               FN_ADD, FN_ADDU: ctrl = ALU_ADD;
               FN_SUB, FN_SUBU: ctrl = ALU_SUB;
               FN_NOR:          ctrl = ALU_NOR;
               FN_XOR:          ctrl = ALU_XOR;
               FN_SLT:          ctrl = ALU_SLT;
               FN_SLL: begin
                  ctrl = ALU_SLL;
                  a    = RtData;
                  b    = sh;
               end
               FN_ROTR: begin
                  ctrl = ALU_ROTR;
                  a    = RtData;
                  b    = sh;
                  bad  = (RsField != RS_ROTR);
               end
               FN_JR: begin
                  ctrl = ALU_JUMP;
                  b    = 32'd0;
               end
               default: bad = 1'b1;
            endcase
         end
         OP_SPECIAL2: begin
            case (Funct)
               FN_MUL: begin
                  ctrl = ALU_MUL;
                  b    = RtData;
               end
               FN_CLO: begin
                  ctrl = ALU_CLZO;
                  b    = 32'd1;
               end
               FN_CLZ: ctrl = ALU_CLZO;
               default: bad = 1'b1;
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
            ctrl = ALU_ADD;
            b    = se;
         end
         OP_SLTI: begin
            ctrl = ALU_SLT;
            b    = se;
         end
         OP_ANDI: begin
            ctrl = ALU_AND;
            b    = ze;
         end
         OP_ORI: begin
            ctrl = ALU_OR;
            b    = ze;
         end
         OP_XORI: begin
            ctrl = ALU_XOR;
            b    = ze;
         end
         OP_BEQ, OP_BNE: begin
            ctrl = ALU_SUB;
            b    = RtData;
         end
         OP_LUI: begin
            ctrl = ALU_SLL;
            a    = ze;
            b    = 32'd16;
         end
         OP_J, OP_JAL: begin
            ctrl = ALU_JUMP;
            a    = 32'd0;
         end
         default: bad = 1'b1;
      endcase
   end

   // Illegal entries still flow through the FIFO, but carry no operands
   always_comb begin
      Illegal    = bad;
      ALUControl = bad ? ALU_AND : ctrl;
      A          = bad ? 32'd0   : a;
      B          = bad ? 32'd0   : b;
   end

endmodule

// File: rtl/alu_op_issue.sv
// Issue stage: decodes an accepted instruction and buffers it in a small FIFO
// whose head drives the ALU. Outputs are purely registered-state driven, so
// input-to-output is never combinational.
module alu_op_issue
   import alu_ctrl_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Flush,
   input  logic             InValid,
   output logic             InReady,
   input  logic [5:0]       Opcode,
   input  logic [5:0]       Funct,
   input  logic [4:0]       RsField,
   input  logic [4:0]       Shamt,
   input  logic [15:0]      Imm16,
   input  logic [31:0]      RsData,
   input  logic [31:0]      RtData,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [3:0]       ALUControl,
   output logic [31:0]      A,
   output logic [31:0]      B,
   output logic             Illegal,
   output logic [CNT_W-1:0] IssueCount
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   entry_t             dec;
   entry_t             head;
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [CW-1:0]      count;
   logic               push, pop;

   alu_op_decode u_dec (
      .Opcode     (Opcode),
      .Funct      (Funct),
      .RsField    (RsField),
      .Shamt      (Shamt),
      .Imm16      (Imm16),
      .RsData     (RsData),
      .RtData     (RtData),
      .ALUControl (dec.ctrl),
      .A          (dec.a),
      .B          (dec.b),
      .Illegal    (dec.illegal)
   );

   assign InReady  = (count < CW'(DEPTH));
   assign OutValid = (count != '0);
   assign push     = InValid && InReady;
   assign pop      = OutValid && OutReady;

   // Entry storage; a push coinciding with Flush is dropped
   always_ff @(posedge Clk) begin
      if (push && !Flush)
         mem[wr_ptr] <= dec;
   end

   // Pointers and occupancy; Flush empties the FIFO next cycle
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (Flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Completed output handshakes; a pop during Flush still counts
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         IssueCount <= '0;
      else if (pop)
         IssueCount <= IssueCount + CNT_W'(1);
   end

   // Head view, forced to zero when empty so reset clears it immediately
   always_comb begin
      head = OutValid ? entry_t'(mem[rd_ptr]) : '0;
      ALUControl = head.ctrl;
      A          = head.a;
      B          = head.b;
      Illegal    = head.illegal;
   end

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed checks of the issue stage followed by a randomized run against a
// queue-based reference model.
module tb_alu_op_issue;

   localparam int DEPTH = 2;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic        ill;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset, Flush, InValid, InReady, OutValid, OutReady, Illegal;
   logic [5:0]  Opcode, Funct;
   logic [4:0]  RsField, Shamt;
   logic [15:0] Imm16;
   logic [31:0] RsData, RtData, A, B;
   logic [3:0]  ALUControl;
   logic [CNT_W-1:0] IssueCount;

   int tests = 0;
   int fails = 0;

   alu_op_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Reset(Reset), .Flush(Flush),
      .InValid(InValid), .InReady(InReady),
      .Opcode(Opcode), .Funct(Funct), .RsField(RsField), .Shamt(Shamt),
      .Imm16(Imm16), .RsData(RsData), .RtData(RtData),
      .OutValid(OutValid), .OutReady(OutReady),
      .ALUControl(ALUControl), .A(A), .B(B), .Illegal(Illegal),
      .IssueCount(IssueCount)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_ins(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                          input logic [4:0] sh, input logic [15:0] imm,
                          input logic [31:0] rsd, input logic [31:0] rtd);
      Opcode = op; Funct = fn; RsField = rs; Shamt = sh; Imm16 = imm;
      RsData = rsd; RtData = rtd;
   endtask

   // Reference decode from the instruction table, using plain numeric values
   function automatic exp_t ref_dec(input logic [5:0] op, input logic [5:0] fn,
                                    input logic [4:0] rs, input logic [4:0] sh,
                                    input logic [15:0] imm,
                                    input logic [31:0] rsd, input logic [31:0] rtd);
      exp_t e;
      logic [31:0] s, z;
      s = {{16{imm[15]}}, imm};
      z = {16'h0, imm};
      e = '{c: 4'd0, a: 32'd0, b: 32'd0, ill: 1'b1};
      if (op == 6'h00) begin
         if (fn == 6'h24)                    e = '{4'd0,  rsd, rtd, 1'b0};
         else if (fn == 6'h25)               e = '{4'd1,  rsd, rtd, 1'b0};
         else if (fn inside {6'h20, 6'h21})  e = '{4'd2,  rsd, rtd, 1'b0};
         else if (fn inside {6'h22, 6'h23})  e = '{4'd6,  rsd, rtd, 1'b0};
         else if (fn == 6'h27)               e = '{4'd3,  rsd, rtd, 1'b0};
         else if (fn == 6'h26)               e = '{4'd4,  rsd, rtd, 1'b0};
         else if (fn == 6'h2A)               e = '{4'd7,  rsd, rtd, 1'b0};
         else if (fn == 6'h00)               e = '{4'd10, rtd, 32'(sh), 1'b0};
         else if (fn == 6'h02 && rs == 5'd1) e = '{4'd13, rtd, 32'(sh), 1'b0};
         else if (fn == 6'h08)               e = '{4'd8,  rsd, 32'd0, 1'b0};
      end else if (op == 6'h1C) begin
         if (fn == 6'h02)      e = '{4'd9,  rsd, rtd,   1'b0};
         else if (fn == 6'h21) e = '{4'd12, rsd, 32'd1, 1'b0};
         else if (fn == 6'h20) e = '{4'd12, rsd, 32'd0, 1'b0};
      end else if (op inside {6'h08, 6'h09, 6'h23, 6'h2B}) e = '{4'd2,  rsd, s, 1'b0};
      else if (op == 6'h0A)                 e = '{4'd7,  rsd, s, 1'b0};
      else if (op == 6'h0C)                 e = '{4'd0,  rsd, z, 1'b0};
      else if (op == 6'h0D)                 e = '{4'd1,  rsd, z, 1'b0};
      else if (op == 6'h0E)                 e = '{4'd4,  rsd, z, 1'b0};
      else if (op inside {6'h04, 6'h05})    e = '{4'd6,  rsd, rtd, 1'b0};
      else if (op == 6'h0F)                 e = '{4'd10, z, 32'd16, 1'b0};
      else if (op inside {6'h02, 6'h03})    e = '{4'd8,  32'd0, 32'd0, 1'b0};
      return e;
   endfunction

   logic [5:0] op_pool [15] = '{6'h00, 6'h00, 6'h00, 6'h1C, 6'h08, 6'h09, 6'h0A, 6'h23,
                                6'h2B, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h0F, 6'h02};
   logic [5:0] fn_pool [13] = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h22, 6'h23, 6'h27, 6'h26,
                                6'h2A, 6'h00, 6'h02, 6'h08, 6'h3F};

   exp_t             q [$];
   exp_t             hd, ne;
   logic [CNT_W-1:0] ecnt;
   logic             pu, po, fl;
   int               k;

   initial begin
      Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
      set_ins(6'h00, 6'h00, 5'd0, 5'd0, 16'h0, 32'd0, 32'd0);
      #3;
      chk("rst_outvalid", OutValid, 0);
      chk("rst_inready", InReady, 1);
      chk("rst_count", IssueCount, 0);
      chk("rst_ctrl", ALUControl, 0);
      @(negedge Clk);
      Reset = 1'b0;
      ecnt = '0;

      // ADDI with negative immediate
      set_ins(6'h08, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'd5, 32'd0);
      InValid = 1'b1; OutReady = 1'b1;
      step();
      InValid = 1'b0;
      chk("addi_vld", OutValid, 1);
      chk("addi_ctrl", ALUControl, 2);
      chk("addi_a", A, 32'd5);
      chk("addi_b", B, 32'hFFFFFFFF);
      chk("addi_ill", Illegal, 0);
      chk("addi_cnt0", IssueCount, 0);
      step();
      chk("addi_cnt1", IssueCount, 1);
      chk("addi_empty", OutValid, 0);

      // LUI then ROTR back to back
      set_ins(6'h0F, 6'h00, 5'd0, 5'd0, 16'h1234, 32'hDEAD, 32'd0);
      InValid = 1'b1;
      step();
      chk("lui_ctrl", ALUControl, 10);
      chk("lui_a", A, 32'h00001234);
      chk("lui_b", B, 32'd16);
      set_ins(6'h00, 6'h02, 5'd1, 5'd8, 16'h0, 32'd0, 32'hAABBCCDD);
      step();
      InValid = 1'b0;
      chk("rotr_ctrl", ALUControl, 13);
      chk("rotr_a", A, 32'hAABBCCDD);
      chk("rotr_b", B, 32'd8);
      step();
      chk("rotr_cnt", IssueCount, 3);

      // Backpressure: fill, hold, then drain in order
      OutReady = 1'b0; InValid = 1'b1;
      set_ins(6'h00, 6'h20, 5'd0, 5'd0, 16'h0, 32'h11, 32'h21);
      step();
      chk("bp_rdy1", InReady, 1);
      chk("bp_head1", A, 32'h11);
      set_ins(6'h00, 6'h20, 5'd0, 5'd0, 16'h0, 32'h12, 32'h22);
      step();
      chk("bp_full", InReady, 0);
      chk("bp_head2", A, 32'h11);
      set_ins(6'h00, 6'h20, 5'd0, 5'd0, 16'h0, 32'h13, 32'h23);
      step();
      chk("bp_hold_rdy", InReady, 0);
      chk("bp_hold_a", A, 32'h11);
      chk("bp_hold_b", B, 32'h21);
      OutReady = 1'b1;
      step();
      chk("bp_pop1_a", A, 32'h12);
      chk("bp_pop1_rdy", InReady, 1);
      step();
      InValid = 1'b0;
      chk("bp_pop2_a", A, 32'h13);
      chk("bp_pop2_b", B, 32'h23);
      step();
      chk("bp_drained", OutValid, 0);
      chk("bp_cnt", IssueCount, 6);

      // Illegal opcode is still issued
      OutReady = 1'b0; InValid = 1'b1;
      set_ins(6'h3F, 6'h20, 5'd3, 5'd4, 16'h5555, 32'h77, 32'h88);
      step();
      InValid = 1'b0;
      chk("ill_vld", OutValid, 1);
      chk("ill_flag", Illegal, 1);
      chk("ill_ctrl", ALUControl, 0);
      chk("ill_a", A, 0);
      chk("ill_b", B, 0);
      OutReady = 1'b1;
      step();
      chk("ill_cnt", IssueCount, 7);

      // SLTI sign-extends, ANDI zero-extends
      InValid = 1'b1;
      set_ins(6'h0A, 6'h00, 5'd0, 5'd0, 16'h8000, 32'd3, 32'd0);
      step();
      chk("slti_ctrl", ALUControl, 7);
      chk("slti_b", B, 32'hFFFF8000);
      set_ins(6'h0C, 6'h00, 5'd0, 5'd0, 16'h8000, 32'd3, 32'd0);
      step();
      InValid = 1'b0;
      chk("andi_ctrl", ALUControl, 0);
      chk("andi_b", B, 32'h00008000);
      chk("andi_ill", Illegal, 0);
      step();

      // Flush while full with push attempt and pop
      OutReady = 1'b0; InValid = 1'b1;
      set_ins(6'h00, 6'h20, 5'd0, 5'd0, 16'h0, 32'h31, 32'h41);
      step();
      step();
      chk("fl_full", InReady, 0);
      OutReady = 1'b1; Flush = 1'b1;
      step();
      Flush = 1'b0; InValid = 1'b0;
      chk("fl_vld", OutValid, 0);
      chk("fl_rdy", InReady, 1);
      chk("fl_cnt", IssueCount, 10);

      // Asynchronous reset mid-stream with two entries buffered
      OutReady = 1'b0; InValid = 1'b1;
      step();
      step();
      InValid = 1'b0;
      chk("ar_pre_vld", OutValid, 1);
      #2 Reset = 1'b1;
      #1;
      chk("ar_vld", OutValid, 0);
      chk("ar_ctrl", ALUControl, 0);
      chk("ar_a", A, 0);
      chk("ar_b", B, 0);
      chk("ar_cnt", IssueCount, 0);
      chk("ar_rdy", InReady, 1);
      @(negedge Clk);
      Reset = 1'b0;
      step();

      // Randomized run against the queue model
      q.delete();
      ecnt = '0;
      for (int i = 0; i < 400; i++) begin
         hd = (q.size() != 0) ? q[0] : '0;
         chk("rnd_vld", OutValid, 32'(q.size() != 0));
         chk("rnd_rdy", InReady, 32'(q.size() < DEPTH));
         chk("rnd_ctrl", ALUControl, 32'(hd.c));
         chk("rnd_a", A, hd.a);
         chk("rnd_b", B, hd.b);
         chk("rnd_ill", Illegal, 32'(hd.ill));
         chk("rnd_cnt", IssueCount, 32'(ecnt));

         k = $urandom_range(0, 15);
         Opcode  = (k == 15) ? 6'($urandom) : op_pool[k];
         k = $urandom_range(0, 12);
         Funct   = (Opcode == 6'h1C) ? fn_pool[$urandom_range(9, 12)] ^ {4'd0, 2'($urandom_range(0, 1)), 1'b0} & 6'h23
                                     : fn_pool[k];
         if (Opcode == 6'h1C && $urandom_range(0, 1) == 1)
            Funct = (($urandom_range(0, 1) == 1) ? 6'h20 : 6'h21);
         RsField = 5'($urandom_range(0, 3));
         Shamt   = 5'($urandom);
         Imm16   = 16'($urandom);
         RsData  = $urandom;
         RtData  = $urandom;
         InValid  = ($urandom_range(0, 3) != 0);
         OutReady = ($urandom_range(0, 2) != 0);
         Flush    = ($urandom_range(0, 24) == 0);

         ne = ref_dec(Opcode, Funct, RsField, Shamt, Imm16, RsData, RtData);
         pu = InValid && (q.size() < DEPTH);
         po = (q.size() != 0) && OutReady;
         fl = Flush;
         step();
         if (po) begin
            void'(q.pop_front());
            ecnt++;
         end
         if (fl)
            q.delete();
         else if (pu)
            q.push_back(ne);
      end
      InValid = 1'b0; Flush = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
